// File: rtl/fv_sb_pkg.sv
// Shared types and sizing helpers for the multi-channel in-order scoreboard.
package fv_sb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } sb_state_e;

   function automatic int calc_chw(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int calc_cw(input int max_trans);
      return $clog2(max_trans) + 1;
   endfunction

   function automatic int calc_lw(input int max_lat);
      return (max_lat > 0) ? $clog2(max_lat + 1) : 1;
   endfunction

endpackage

// File: rtl/fv_sb_track_ch.sv
// One channel of the scoreboard: tracks a single sampled transaction with the
// counter technique and raises sticky integrity / protocol error flags.
module fv_sb_track_ch
   import fv_sb_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int MAX_TRANS = 16,
   parameter int MAX_LAT   = 64,
   parameter int CW        = 5
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              inc,
   input  logic              dec,
   input  logic              sample_req,
   input  logic [DWIDTH-1:0] push_data,
   input  logic [DWIDTH-1:0] pop_data,
   output sb_state_e         state,
   output logic [CW-1:0]     cntr,
   output logic              done,
   output logic              err_data,
   output logic              err_timeout,
   output logic              err_overflow,
   output logic              err_underflow
);

   localparam int            LW       = calc_lw(MAX_LAT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_TRANS);
   localparam logic [LW-1:0] LAT_SAT  = LW'(MAX_LAT);
   localparam logic [LW-1:0] LAT_LAST = (MAX_LAT > 0) ? LW'(MAX_LAT - 1) : '0;

   sb_state_e         state_q, state_d;
   logic [CW-1:0]     cntr_q, cntr_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic [DWIDTH-1:0] tracked_q, tracked_d;
   logic              ed_q, ed_d, to_q, to_d, of_q, of_d, uf_q, uf_d;
   logic              dec_ok;
   logic              compare;

   // A pop only retires an item when something is actually in flight.
   assign dec_ok  = dec && (cntr_q != '0);
   assign compare = (state_q == TRACK) && dec && (cntr_q == CW'(1));

   always_comb begin
      state_d   = state_q;
      cntr_d    = cntr_q;
      lat_d     = lat_q;
      tracked_d = tracked_q;
      ed_d      = ed_q;
      to_d      = to_q;
      of_d      = of_q;
      uf_d      = uf_q;
      case (state_q)
         IDLE: begin
            if (dec && !dec_ok) uf_d = 1'b1;
            if (inc && (cntr_q == CNT_MAX) && !dec) begin
               of_d   = 1'b1;
               cntr_d = CNT_MAX;
            end else begin
               cntr_d = cntr_q + CW'(inc) - CW'(dec_ok);
            end
            if (inc && sample_req) begin
               tracked_d = push_data;
               lat_d     = '0;
               state_d   = TRACK;
            end
         end
         TRACK: begin
            // Later pushes sit behind the tracked item, so they are not counted.
            if (lat_q != LAT_SAT) lat_d = lat_q + LW'(1);
            if (dec && (cntr_q == '0)) begin
               uf_d = 1'b1;
            end else if (compare) begin
               if (pop_data != tracked_q) ed_d = 1'b1;
               cntr_d  = '0;
               state_d = DONE;
            end else if (dec) begin
               cntr_d = cntr_q - CW'(1);
            end
            if ((MAX_LAT > 0) && !compare && (lat_q == LAT_LAST)) to_d = 1'b1;
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cntr_q  <= '0;
         lat_q   <= '0;
         ed_q    <= 1'b0;
         to_q    <= 1'b0;
         of_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         lat_q   <= lat_d;
         ed_q    <= ed_d;
         to_q    <= to_d;
         of_q    <= of_d;
         uf_q    <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      tracked_q <= tracked_d;
   end

   assign state         = state_q;
   assign cntr          = cntr_q;
   assign done          = (state_q == DONE);
   assign err_data      = ed_q;
   assign err_timeout   = to_q;
   assign err_overflow  = of_q;
   assign err_underflow = uf_q;

endmodule

// File: rtl/fv_sb_inorder_mc.sv
// Multi-channel in-order data-integrity scoreboard: decodes the shared
// push/pop buses per channel and instantiates one tracker per channel.
module fv_sb_inorder_mc
   import fv_sb_pkg::*;
#(
   parameter  int DWIDTH    = 8,
   parameter  int NUM_CH    = 4,
   parameter  int MAX_TRANS = 16,
   parameter  int MAX_LAT   = 64,
   localparam int CHW       = calc_chw(NUM_CH),
   localparam int CW        = calc_cw(MAX_TRANS)
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 push_valid,
   input  logic [CHW-1:0]       push_ch,
   input  logic [DWIDTH-1:0]    push_data,
   input  logic                 pop_valid,
   input  logic [CHW-1:0]       pop_ch,
   input  logic [DWIDTH-1:0]    pop_data,
   input  logic [NUM_CH-1:0]    sample_req,
   output logic [NUM_CH-1:0]    done,
   output logic [NUM_CH-1:0]    err_data,
   output logic [NUM_CH-1:0]    err_timeout,
   output logic [NUM_CH-1:0]    err_overflow,
   output logic [NUM_CH-1:0]    err_underflow,
   output logic [NUM_CH*CW-1:0] cntr
);

   sb_state_e ch_state [NUM_CH];

   // push_valid/pop_valid are one-cycle qualifiers with no backpressure: each
   // high cycle is exactly one transfer on the tagged channel; ids >= NUM_CH
   // match no tracker and are dropped.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic inc;
      logic dec;
      assign inc = push_valid && (push_ch == CHW'(c));
      assign dec = pop_valid && (pop_ch == CHW'(c));

      fv_sb_track_ch #(
         .DWIDTH    (DWIDTH),
         .MAX_TRANS (MAX_TRANS),
         .MAX_LAT   (MAX_LAT),
         .CW        (CW)
      ) u_track (
         .clk           (clk),
         .rstn          (rstn),
         .inc           (inc),
         .dec           (dec),
         .sample_req    (sample_req[c]),
         .push_data     (push_data),
         .pop_data      (pop_data),
         .state         (ch_state[c]),
         .cntr          (cntr[c*CW +: CW]),
         .done          (done[c]),
         .err_data      (err_data[c]),
         .err_timeout   (err_timeout[c]),
         .err_overflow  (err_overflow[c]),
         .err_underflow (err_underflow[c])
      );

      ap_cntr_max: assert property (@(posedge clk) disable iff (!rstn)
         cntr[c*CW +: CW] <= CW'(MAX_TRANS));
      ap_done_zero: assert property (@(posedge clk) disable iff (!rstn)
         (ch_state[c] == DONE) |-> (cntr[c*CW +: CW] == '0));

`ifdef FORMAL
      // Proof obligations on the bound DUT; benches that inject faults leave FORMAL undefined.
      ap_no_err_data: assert property (@(posedge clk) disable iff (!rstn) !err_data[c]);
      ap_no_err_to:   assert property (@(posedge clk) disable iff (!rstn) !err_timeout[c]);
      ap_no_err_of:   assert property (@(posedge clk) disable iff (!rstn) !err_overflow[c]);
      ap_no_err_uf:   assert property (@(posedge clk) disable iff (!rstn) !err_underflow[c]);
      ap_live:        assert property (@(posedge clk) disable iff (!rstn)
         (ch_state[c] == TRACK) |-> s_eventually (ch_state[c] == DONE));
`endif
   end

endmodule

// File: tb/tb_fv_sb_inorder_mc.sv
// Directed and randomized bench for the in-order scoreboard, checked against a
// per-channel behavioural model of sampling, counting and error rules.
module tb_fv_sb_inorder_mc;

   localparam int DW  = 8;
   localparam int NCH = 4;
   localparam int MT  = 16;
   localparam int ML  = 64;
   localparam int CHW = 2;
   localparam int CW  = 5;

   logic              clk = 1'b0;
   logic              rstn;
   logic              push_valid;
   logic [CHW-1:0]    push_ch;
   logic [DW-1:0]     push_data;
   logic              pop_valid;
   logic [CHW-1:0]    pop_ch;
   logic [DW-1:0]     pop_data;
   logic [NCH-1:0]    sample_req;
   logic [NCH-1:0]    done, err_data, err_timeout, err_overflow, err_underflow;
   logic [NCH*CW-1:0] cntr;

   int n_checks = 0;
   int n_pass   = 0;

   // model: mode 0 = waiting for sample, 1 = tracking, 2 = finished
   int             m_mode [NCH];
   int             m_cnt  [NCH];
   int             m_lat  [NCH];
   logic [DW-1:0]  m_exp  [NCH];
   logic [NCH-1:0] m_ed, m_to, m_of, m_uf;
   logic [DW-1:0]  exp_q  [NCH][$];

   fv_sb_inorder_mc #(.DWIDTH(DW), .NUM_CH(NCH), .MAX_TRANS(MT), .MAX_LAT(ML)) dut (
      .clk(clk), .rstn(rstn),
      .push_valid(push_valid), .push_ch(push_ch), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ch(pop_ch), .pop_data(pop_data),
      .sample_req(sample_req), .done(done), .err_data(err_data),
      .err_timeout(err_timeout), .err_overflow(err_overflow),
      .err_underflow(err_underflow), .cntr(cntr)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timeout");
   end

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_mode[c] = 0;
         m_cnt[c]  = 0;
         m_lat[c]  = 0;
         exp_q[c].delete();
      end
      m_ed = '0; m_to = '0; m_of = '0; m_uf = '0;
   endtask

   task automatic model_step();
      bit inc, dec, pop_ok, cmp;
      for (int c = 0; c < NCH; c++) begin
         inc = push_valid && (int'(push_ch) == c);
         dec = pop_valid && (int'(pop_ch) == c);
         if (m_mode[c] == 0) begin
            pop_ok = dec && (m_cnt[c] > 0);
            if (dec && !pop_ok) m_uf[c] = 1'b1;
            if (inc && (m_cnt[c] == MT) && !dec) m_of[c] = 1'b1;
            m_cnt[c] = m_cnt[c] + int'(inc) - int'(pop_ok);
            if (m_cnt[c] > MT) m_cnt[c] = MT;
            if (inc && sample_req[c]) begin
               m_exp[c]  = push_data;
               m_mode[c] = 1;
               m_lat[c]  = 0;
            end
         end else if (m_mode[c] == 1) begin
            m_lat[c]++;
            cmp = dec && (m_cnt[c] == 1);
            if (dec && (m_cnt[c] == 0)) m_uf[c] = 1'b1;
            else if (cmp) begin
               if (pop_data !== m_exp[c]) m_ed[c] = 1'b1;
               m_mode[c] = 2;
               m_cnt[c]  = 0;
            end else if (dec) m_cnt[c]--;
            if (!cmp && (ML > 0) && (m_lat[c] == ML)) m_to[c] = 1'b1;
         end
      end
   endtask

   function automatic logic [NCH*CW-1:0] exp_cntr();
      logic [NCH*CW-1:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++) r[c*CW +: CW] = CW'(m_cnt[c]);
      return r;
   endfunction

   function automatic logic [NCH-1:0] exp_done();
      logic [NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (m_mode[c] == 2);
      return r;
   endfunction

   // driver tasks
   task automatic cyc(input logic pv, input int pc, input logic [DW-1:0] pd,
                      input logic ov, input int oc, input logic [DW-1:0] od,
                      input logic [NCH-1:0] sr);
      @(negedge clk);
      push_valid = pv; push_ch = CHW'(pc); push_data = pd;
      pop_valid  = ov; pop_ch  = CHW'(oc); pop_data  = od;
      sample_req = sr;
      @(posedge clk);
      model_step();
      #1;
      push_valid = 1'b0; pop_valid = 1'b0; sample_req = '0;
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d, input logic [NCH-1:0] sr);
      cyc(1'b1, ch, d, 1'b0, 0, '0, sr);
   endtask

   task automatic pop(input int ch, input logic [DW-1:0] d);
      cyc(1'b0, 0, '0, 1'b1, ch, d, '0);
   endtask

   task automatic idle();
      cyc(1'b0, 0, '0, 1'b0, 0, '0, '0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstn = 1'b0;
      push_valid = 1'b0; pop_valid = 1'b0; sample_req = '0;
      push_ch = '0; pop_ch = '0; push_data = '0; pop_data = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      model_reset();
   endtask

   // scenarios
   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({done, err_data, err_timeout, err_overflow, err_underflow, cntr} !== '0)
         $display("FAIL reset_outputs: got %h want 0",
                  {done, err_data, err_timeout, err_overflow, err_underflow, cntr});
      else n_pass++;
   endtask

   task automatic test_inorder();
      push(0, 8'h10, 4'b0000);
      push(0, 8'h11, 4'b0000);
      push(0, 8'h12, 4'b0001);
      push(0, 8'h13, 4'b0000);
      n_checks++;
      if (cntr[4:0] !== 5'd3) $display("FAIL inorder_cntr_tracked: got %0d want 3", cntr[4:0]);
      else n_pass++;
      pop(0, 8'h10);
      pop(0, 8'h11);
      n_checks++;
      if (done !== 4'b0000) $display("FAIL inorder_done_early: got %b want 0000", done);
      else n_pass++;
      pop(0, 8'h12);
      n_checks++;
      if (done !== 4'b0001) $display("FAIL inorder_done: got %b want 0001", done);
      else n_pass++;
      n_checks++;
      if ({err_data, err_timeout, err_overflow, err_underflow, cntr} !== '0)
         $display("FAIL inorder_clean: got %h want 0",
                  {err_data, err_timeout, err_overflow, err_underflow, cntr});
      else n_pass++;
   endtask

   task automatic test_swap();
      apply_reset();
      push(0, 8'h10, 4'b0000);
      push(0, 8'h11, 4'b0000);
      push(0, 8'h12, 4'b0001);
      push(0, 8'h13, 4'b0000);
      pop(0, 8'h10);
      pop(0, 8'h12);
      n_checks++;
      if (err_data !== 4'b0000) $display("FAIL swap_err_early: got %b want 0000", err_data);
      else n_pass++;
      pop(0, 8'h11);
      n_checks++;
      if (err_data !== 4'b0001) $display("FAIL swap_err_data: got %b want 0001", err_data);
      else n_pass++;
      n_checks++;
      if (done !== 4'b0001) $display("FAIL swap_done: got %b want 0001", done);
      else n_pass++;
   endtask

   task automatic test_isolation();
      apply_reset();
      push(1, 8'h20, 4'b0000);
      push(2, 8'h30, 4'b0000);
      push(1, 8'h21, 4'b0000);
      push(2, 8'h31, 4'b0100);
      push(1, 8'h22, 4'b0000);
      push(2, 8'h32, 4'b0000);
      pop(1, 8'h22);
      pop(1, 8'h20);
      pop(1, 8'h21);
      n_checks++;
      if (cntr[9:5] !== 5'd0) $display("FAIL iso_cntr_ch1: got %0d want 0", cntr[9:5]);
      else n_pass++;
      pop(2, 8'h30);
      pop(2, 8'h31);
      n_checks++;
      if (done !== 4'b0100) $display("FAIL iso_done: got %b want 0100", done);
      else n_pass++;
      n_checks++;
      if ({err_data, err_underflow} !== '0)
         $display("FAIL iso_errors: got %h want 0", {err_data, err_underflow});
      else n_pass++;
   endtask

   task automatic test_timeout();
      apply_reset();
      push(3, 8'h5A, 4'b1000);
      repeat (ML - 1) idle();
      n_checks++;
      if (err_timeout !== 4'b0000) $display("FAIL to_early: got %b want 0000", err_timeout);
      else n_pass++;
      idle();
      n_checks++;
      if (err_timeout !== 4'b1000) $display("FAIL to_at_limit: got %b want 1000", err_timeout);
      else n_pass++;
      pop(3, 8'h5A);
      n_checks++;
      if (done !== 4'b1000) $display("FAIL to_late_done: got %b want 1000", done);
      else n_pass++;
      n_checks++;
      if ({err_data, err_timeout} !== {4'b0000, 4'b1000})
         $display("FAIL to_late_flags: got %h want 08", {err_data, err_timeout});
      else n_pass++;
   endtask

   task automatic test_overflow_underflow();
      apply_reset();
      for (int i = 0; i < MT; i++) push(0, DW'(i), 4'b0000);
      n_checks++;
      if ({err_overflow, cntr[4:0]} !== {4'b0000, 5'd16})
         $display("FAIL of_full: got %h want %h", {err_overflow, cntr[4:0]}, {4'b0000, 5'd16});
      else n_pass++;
      push(0, 8'hEE, 4'b0000);
      n_checks++;
      if ({err_overflow, cntr[4:0]} !== {4'b0001, 5'd16})
         $display("FAIL of_sat: got %h want %h", {err_overflow, cntr[4:0]}, {4'b0001, 5'd16});
      else n_pass++;
      pop(1, 8'h00);
      n_checks++;
      if ({err_underflow, cntr[9:5]} !== {4'b0010, 5'd0})
         $display("FAIL uf_ch1: got %h want %h", {err_underflow, cntr[9:5]}, {4'b0010, 5'd0});
      else n_pass++;
      cyc(1'b1, 2, 8'h44, 1'b1, 2, 8'h00, 4'b0000);
      n_checks++;
      if ({err_underflow, cntr[14:10]} !== {4'b0110, 5'd1})
         $display("FAIL uf_same_cycle_push: got %h want %h",
                  {err_underflow, cntr[14:10]}, {4'b0110, 5'd1});
      else n_pass++;
      cyc(1'b1, 0, 8'h55, 1'b1, 0, 8'h00, 4'b0000);
      n_checks++;
      if (cntr[4:0] !== 5'd16) $display("FAIL net_zero_at_max: got %0d want 16", cntr[4:0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_track();
      apply_reset();
      push(0, 8'h77, 4'b0001);
      pop(1, 8'h00);
      n_checks++;
      if ({err_underflow, cntr[4:0]} !== {4'b0010, 5'd1})
         $display("FAIL mid_pre: got %h want %h", {err_underflow, cntr[4:0]}, {4'b0010, 5'd1});
      else n_pass++;
      @(negedge clk);
      rstn = 1'b0;
      #2;
      n_checks++;
      if ({done, err_data, err_timeout, err_overflow, err_underflow, cntr} !== '0)
         $display("FAIL mid_async_clear: got %h want 0",
                  {done, err_data, err_timeout, err_overflow, err_underflow, cntr});
      else n_pass++;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      model_reset();
      test_inorder();
   endtask

   task automatic test_random_traffic();
      logic          pv, ov;
      int            pc, oc;
      logic [DW-1:0] pd, od;
      logic [NCH-1:0] sr;
      for (int i = 0; i < 800; i++) begin
         if (i % 100 == 0) apply_reset();
         pc = $urandom_range(0, NCH - 1);
         oc = $urandom_range(0, NCH - 1);
         pd = DW'($urandom);
         od = '0;
         ov = ($urandom_range(0, 99) < 50) && (exp_q[oc].size() > 0);
         if (ov) begin
            od = exp_q[oc].pop_front();
            if ($urandom_range(0, 19) == 0) od = od ^ 8'h01;
         end
         pv = ($urandom_range(0, 99) < 60) && (exp_q[pc].size() < 14);
         if (pv) exp_q[pc].push_back(pd);
         for (int c = 0; c < NCH; c++) sr[c] = ($urandom_range(0, 5) == 0);
         cyc(pv, pc, pd, ov, oc, od, sr);
         n_checks++;
         if (cntr !== exp_cntr()) $display("FAIL rnd_cntr @%0d: got %h want %h", i, cntr, exp_cntr());
         else n_pass++;
         n_checks++;
         if (done !== exp_done()) $display("FAIL rnd_done @%0d: got %b want %b", i, done, exp_done());
         else n_pass++;
         n_checks++;
         if (err_data !== m_ed) $display("FAIL rnd_err_data @%0d: got %b want %b", i, err_data, m_ed);
         else n_pass++;
         n_checks++;
         if (err_timeout !== m_to) $display("FAIL rnd_err_timeout @%0d: got %b want %b", i, err_timeout, m_to);
         else n_pass++;
         n_checks++;
         if ({err_overflow, err_underflow} !== {m_of, m_uf})
            $display("FAIL rnd_err_ou @%0d: got %h want %h", i, {err_overflow, err_underflow}, {m_of, m_uf});
         else n_pass++;
      end
   endtask

   initial begin
      rstn = 1'b0;
      push_valid = 1'b0; pop_valid = 1'b0; sample_req = '0;
      push_ch = '0; pop_ch = '0; push_data = '0; pop_data = '0;
      model_reset();
      test_reset();
      test_inorder();
      test_swap();
      test_isolation();
      test_timeout();
      test_overflow_underflow();
      test_reset_mid_track();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fv_sb_inorder_mc.md
# fv_sb_inorder_mc

Multi-channel in-order data-integrity scoreboard using the counter technique. It tracks one symbolically chosen transaction per channel across NUM_CH independent in-order streams (interleaved on shared push/pop buses, tagged by channel ID) and checks that the transaction exits with unmodified data. It adds a bounded-latency watchdog, counter overflow/underflow detection and sticky error outputs, so the same block serves formal (free sample_req) and simulation (driven sample_req) benches. It binds alongside any per-channel in-order DUT (multi-queue FIFO, VC buffer, arbitrated pipe).

## Interface
- DWIDTH, 8, data width
- NUM_CH, 4, number of independent in-order channels (≥1)
- MAX_TRANS, 16, max in-flight transactions per channel; sizes counters to $clog2(MAX_TRANS)+1 bits (CW)
- MAX_LAT, 64, max cycles from sample to compare; 0 disables the watchdog
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- push_valid  in  1  transaction enters DUT
- push_ch  in  CHW=max(1,$clog2(NUM_CH))  channel of push
- push_data  in  DWIDTH  data entering
- pop_valid  in  1  transaction exits DUT
- pop_ch  in  CHW  channel of pop
- pop_data  in  DWIDTH  data exiting
- sample_req  in  NUM_CH  per-channel sample request; left undriven (symbolic) in formal
- done  out  NUM_CH  sampled transaction of channel c has been compared
- err_data  out  NUM_CH  sticky: data mismatch at compare
- err_timeout  out  NUM_CH  sticky: compare not reached within MAX_LAT
- err_overflow  out  NUM_CH  sticky: counter would exceed MAX_TRANS
- err_underflow  out  NUM_CH  sticky: pop with zero in flight
- cntr  out  NUM_CH*CW  per-channel counters, channel c at [c*CW +: CW], debug

## Operation
- Per channel c: inc = push_valid && push_ch==c; dec = pop_valid && pop_ch==c.
- FSM per channel: IDLE, TRACK, DONE.
- IDLE: cntr += inc − dec. On inc && sample_req[c]: capture push_data into tracked_data, cntr_next = cntr + 1 − dec, go TRACK, clear lat counter.
- TRACK: pushes on c no longer counted (inc ignored). On dec: if cntr==1, compare pop_data to tracked_data; on mismatch set err_data[c]; go DONE with cntr_next=0; otherwise cntr−1. lat increments every cycle in TRACK.
- DONE: terminal until reset; cntr frozen at 0; pops/pushes on c ignored (no underflow/overflow checks).
- Underflow: dec with cntr==0 in IDLE or TRACK → set err_underflow[c]; counter does not decrement (a same-cycle inc still applies in IDLE). Pop never returns a same-cycle push.
- Overflow: counted inc with cntr==MAX_TRANS and no dec → set err_overflow[c]; counter saturates at MAX_TRANS.
- Timeout (MAX_LAT>0): in TRACK, lat reaching MAX_LAT without compare → set err_timeout[c]; FSM stays TRACK, late compare still checked.
- Simultaneous inc and dec on same channel: net 0. Different channels: independent.
- pop_ch/push_ch ≥ NUM_CH: ignored.
- All err bits sticky until reset.
- Built-in assertions (disable iff !rstn): each err bit never rises; TRACK |-> s_eventually DONE; cntr ≤ MAX_TRANS.

## Timing
- Reset: FSMs IDLE, cntr=0, lat=0, done=0, all err=0; tracked_data not reset.
- All outputs registered: err/done visible the cycle after the triggering edge.
- Reset asserted mid-TRACK: state, counters and errors cleared asynchronously; no compare occurs.
- Zero combinational paths input→output.

## Structure
- Package fv_sb_pkg: sb_state_e {IDLE, TRACK, DONE}, function for CHW, CW localparam helper.
- Sub-module fv_sb_track_ch: one channel's FSM, counter, lat counter, tracked_data and error flags; top instantiates NUM_CH via generate and decodes inc/dec.

## Test plan
- Ch0 push A0..A3 (0x10–0x13), sample on 0x12, pops in order → done[0]=1 cycle after third pop, err_data=0.
- Same, DUT swaps 2nd/3rd pops on ch0 → err_data[0]=1 cycle after third pop.
- Interleave ch1/ch2 pushes, sample ch2 item 2 of 3, ch1 pops reordered freely → done[2]=1, err_data all 0 (channel isolation).
- Ch3 sampled, no pops for 64 cycles (MAX_LAT=64) → err_timeout[3]=1 at lat 64; later correct pop → done[3]=1, err_data[3]=0.
- Ch0 17 pushes, no pops (MAX_TRANS=16) → err_overflow[0]=1, cntr[0]=16; pop on ch1 at cntr 0 → err_underflow[1]=1.
- rstn low while ch0 in TRACK → next cycle all outputs 0; re-run first scenario passes.
